irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Programmable priority interrupt controller on the system device bus, mapped at 0x00007F20–0x00007F2F as a third bridge device.
- Collects six device interrupt requests and applies per-source mask and edge/level mode.
- Tracks pending and in-service state and drives the prioritised HWInt[7:2] lines into CP0.
- CPU acknowledges an interrupt by reading VEC and ends it by writing EOI.

Parameters:
- NSRC, 6, number of interrupt sources; fixed to HWInt[7:2] width.
- BASE_ADDR, 32'h00007F20, base address; decode uses addr[31:4].

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- dev_addr  input  32  device bus address from bridge.
- dev_wd  input  32  device bus write data.
- we  input  1  write strobe; bridge gates it with the address hit.
- re  input  1  read strobe; only a read of VEC has side effects.
- rd  output  32  combinational read data.
- irq_in  input  6  device requests, synchronous to clk; bit0 has highest priority.
- hw_int  output  6  registered, bit i drives HWInt[i+2].

Behaviour:
- Register map, offset from dev_addr[3:2]; dev_addr[1:0] ignored:
  - 0x0 MASK: RW, bits[5:0]; 1 = enabled.
  - 0x4 PEND: read = pend[5:0]; write-1-to-clear, applied to edge-mode bits only.
  - 0x8 MODE: RW, bits[5:0]; 1 = edge, 0 = level.
  - 0xC VEC: read = {valid[31], 28'b0, idx[2:0]}; any write = EOI.
  - Unused read bits return 0.
- Reset: mask, pend, mode, isr, irq_q and hw_int all cleared to 0.
- irq_q is a one-cycle registered copy of irq_in.
- Edge mode: pend[i] sets at an edge where irq_in[i]=1 and irq_q[i]=0.
  - Pend stays set until W1C or VEC acknowledge.
  - Set has priority over a same-cycle clear.
- Level mode: pend[i] <= irq_in[i] every cycle. W1C and acknowledge do not clear it.
- top = index of lowest set isr bit, or 6 if isr = 0.
- eligible[i] = pend[i] & mask[i] & (i < top).
- valid = |eligible; idx = lowest set eligible index.
- hw_int <= eligible each cycle. Latency is 2 edges from irq_in high: pend at edge k, hw_int at edge k+1.
- VEC read (re & offset 0xC & valid) on the same edge:
  - isr[idx] <= 1.
  - pend[idx] <= 0 if edge mode, unless a new edge on that source arrives in the same cycle.
- VEC read with valid=0: returns 0, no state change.
- EOI write: clears the lowest set isr bit. No effect if isr = 0.
- A VEC read and an EOI write never occur in the same cycle (single bus); no arbitration needed.
- Nesting: a higher-priority source may be acknowledged while a lower one is in service. Equal or lower priority is blocked until EOI.
- Mode change at runtime takes effect next edge; pend bits are not altered by it.
- Masking a pending source drops its hw_int bit next edge; pend is retained.
- Reset asserted mid-operation clears all state immediately (async) and hw_int goes 0 with no clock.

Test Plan:
- Reset, then MASK=0x3F, MODE=0x3F; pulse irq_in[3] for 1 cycle:
  - PEND reads 0x08.
  - hw_int=6'b001000 one edge after pend sets.
  - VEC read returns 0x80000003; PEND then reads 0.
  - hw_int=0 while isr[3]=1.
- Pend sources 4 and 1 together:
  - VEC returns idx 1.
  - EOI, then VEC returns idx 4.
  - EOI leaves isr=0 and hw_int=0.
- Nesting: acknowledge source 5, then raise source 0:
  - hw_int[0] asserts and VEC returns 0x80000000.
  - Raising source 5 again while isr={0,5} leaves hw_int=0.
- Level mode, MODE=0, irq_in[2] held high:
  - W1C to PEND and VEC acknowledge do not clear pend[2].
  - Dropping irq_in[2] clears pend one edge later.
- Mask behaviour: MASK=0 with edge on source 1:
  - PEND=0x02, hw_int=0, VEC valid=0.
  - Writing MASK=0x02 raises hw_int[1] on the next edge.
- Simultaneous events and reset:
  - A W1C on bit 2 coinciding with a new edge on source 2 leaves pend[2]=1.
  - Asserting reset_n=0 between clock edges clears hw_int and all registers asynchronously.

Source files
------------

// File: rtl/irq_ctrl.sv
// Six-source programmable priority interrupt controller on the device bus.
// Requests are pended (edge or level), masked, priority-gated by in-service state and driven onto HWInt[7:2].
module irq_ctrl #(
  parameter int          NSRC      = 6,
  parameter logic [31:0] BASE_ADDR = 32'h00007F20
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     dev_addr,
  input  logic [31:0]     dev_wd,
  input  logic            we,
  input  logic            re,
  output logic [31:0]     rd,
  input  logic [NSRC-1:0] irq_in,
  output logic [NSRC-1:0] hw_int
);

  logic [NSRC-1:0] mask, mode, pend, isr, irq_q;
  logic [NSRC-1:0] prio_ok, eligible, edge_set, w1c, ack_vec, eoi_vec, pend_next;
  logic [2:0]      idx;
  logic            valid, hit, ack, eoi;
  logic [1:0]      offset;
  logic            unused_bits;

  assign unused_bits = ^{dev_addr[1:0], dev_wd[31:NSRC]};

  assign hit    = (dev_addr[31:4] == BASE_ADDR[31:4]);
  assign offset = dev_addr[3:2];

  // A source may be serviced only if no isr bit at or above its priority is set.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    prio_ok = '0;
    for (int i = 0; i < NSRC; i++) begin
      seen       = seen | isr[i];
      prio_ok[i] = ~seen;
    end
  end

  assign eligible = pend & mask & prio_ok;
  assign valid    = |eligible;

  always_comb begin
    idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) idx = 3'(i);
    end
  end

  assign edge_set = irq_in & ~irq_q;
  assign ack      = hit & re & (offset == 2'd3) & valid;
  assign eoi      = hit & we & (offset == 2'd3);
  assign w1c      = (hit & we & (offset == 2'd1)) ? dev_wd[NSRC-1:0] : '0;
  assign ack_vec  = ack ? (NSRC'(1) << idx) : '0;
  assign eoi_vec  = eoi ? (isr & (~isr + NSRC'(1))) : '0;

  // A new edge wins over a same-cycle W1C or acknowledge; level sources just follow the pin.
  always_comb begin
    pend_next = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (mode[i]) pend_next[i] = edge_set[i] | (pend[i] & ~w1c[i] & ~ack_vec[i]);
      else         pend_next[i] = irq_in[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      mode   <= '0;
      pend   <= '0;
      isr    <= '0;
      irq_q  <= '0;
      hw_int <= '0;
    end else begin
      irq_q  <= irq_in;
      pend   <= pend_next;
      isr    <= (isr | ack_vec) & ~eoi_vec;
      hw_int <= eligible;
      if (hit && we && offset == 2'd0) mask <= dev_wd[NSRC-1:0];
      if (hit && we && offset == 2'd2) mode <= dev_wd[NSRC-1:0];
    end
  end

  always_comb begin
    rd = 32'h0;
    if (hit) begin
      unique case (offset)
        2'd0: rd = {{(32-NSRC){1'b0}}, mask};
        2'd1: rd = {{(32-NSRC){1'b0}}, pend};
        2'd2: rd = {{(32-NSRC){1'b0}}, mode};
        2'd3: rd = valid ? {1'b1, 28'b0, idx} : 32'h0;
        default: rd = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios plus random traffic against a
// behavioural model of pend/isr/priority expressed per source.
module tb_irq_ctrl;
  localparam logic [31:0] BASE = 32'h00007F20;
  localparam int OP_IDLE = 0, OP_RD = 1, OP_WR = 2;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [31:0] dev_addr = '0, dev_wd = '0, rd;
  logic        we = 1'b0, re = 1'b0;
  logic [5:0]  irq_in = '0, hw_int;
  logic [31:0] last_rd;

  int errors = 0, checks = 0;

  bit [5:0] m_mask, m_mode, m_pend, m_isr, m_irqq, m_hw;

  irq_ctrl #(.NSRC(6), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .dev_addr(dev_addr), .dev_wd(dev_wd),
    .we(we), .re(re), .rd(rd), .irq_in(irq_in), .hw_int(hw_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mask = 0; m_mode = 0; m_pend = 0; m_isr = 0; m_irqq = 0; m_hw = 0;
  endtask

  // Highest-priority source currently in service, 6 when none.
  function automatic int m_top();
    for (int i = 0; i < 6; i++) if (m_isr[i]) return i;
    return 6;
  endfunction

  function automatic bit [5:0] m_elig();
    bit [5:0] e;
    int t;
    e = 0;
    t = m_top();
    for (int i = 0; i < 6; i++) if (m_pend[i] && m_mask[i] && i < t) e[i] = 1'b1;
    return e;
  endfunction

  function automatic int m_idx();
    bit [5:0] e;
    e = m_elig();
    for (int i = 0; i < 6; i++) if (e[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input int off);
    int k;
    case (off)
      0: return {26'b0, m_mask};
      1: return {26'b0, m_pend};
      2: return {26'b0, m_mode};
      default: begin
        k = m_idx();
        return (k >= 0) ? (32'h80000000 | 32'(k)) : 32'h0;
      end
    endcase
  endfunction

  // One bus cycle: drive, check read data, advance model, clock, check hw_int.
  task automatic step(input bit [5:0] irq, input int op, input int off, input bit [31:0] wd);
    bit [5:0] edges, w1c, n_pend, n_isr, n_hw;
    int ai, t;
    irq_in   = irq;
    we       = (op == OP_WR);
    re       = (op == OP_RD);
    dev_addr = BASE + 32'(off * 4);
    dev_wd   = wd;
    #1;
    last_rd = rd;
    if (op == OP_RD) chk($sformatf("rd_off%0d", off), rd, m_read(off));
    edges = irq & ~m_irqq;
    ai    = (op == OP_RD && off == 3) ? m_idx() : -1;
    w1c   = (op == OP_WR && off == 1) ? wd[5:0] : 6'h0;
    n_hw  = m_elig();
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) n_pend[i] = edges[i] ? 1'b1 : ((w1c[i] || ai == i) ? 1'b0 : m_pend[i]);
      else           n_pend[i] = irq[i];
    end
    n_isr = m_isr;
    if (ai >= 0) n_isr[ai] = 1'b1;
    if (op == OP_WR && off == 3) begin
      t = m_top();
      if (t < 6) n_isr[t] = 1'b0;
    end
    @(posedge clk);
    #1;
    if (op == OP_WR && off == 0) m_mask = wd[5:0];
    if (op == OP_WR && off == 2) m_mode = wd[5:0];
    m_pend = n_pend; m_isr = n_isr; m_hw = n_hw; m_irqq = irq;
    chk("hw_int", {26'b0, hw_int}, {26'b0, m_hw});
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic peek_all_zero(input string tag);
    for (int o = 0; o < 4; o++) begin
      dev_addr = BASE + 32'(o * 4);
      #1;
      chk($sformatf("%s_off%0d", tag, o), rd, 32'h0);
    end
  endtask

  initial begin
    m_reset();
    #12;
    chk("reset_hw", {26'b0, hw_int}, 32'h0);
    peek_all_zero("reset_rd");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single edge on source 3
    step(6'h00, OP_WR, 0, 32'h3F);
    step(6'h00, OP_WR, 2, 32'h3F);
    step(6'h08, OP_IDLE, 0, 0);
    step(6'h00, OP_RD, 1, 0);
    chk("pend_08", last_rd, 32'h08);
    chk("hw_08", {26'b0, hw_int}, 32'h08);
    step(6'h00, OP_RD, 3, 0);
    chk("vec_3", last_rd, 32'h80000003);
    step(6'h00, OP_RD, 1, 0);
    chk("pend_clr", last_rd, 32'h0);
    chk("hw_isr3", {26'b0, hw_int}, 32'h0);
    step(6'h00, OP_WR, 3, 0);

    // Sources 4 and 1 together
    step(6'h12, OP_IDLE, 0, 0);
    step(6'h00, OP_IDLE, 0, 0);
    step(6'h00, OP_RD, 3, 0);
    chk("vec_1", last_rd, 32'h80000001);
    step(6'h00, OP_WR, 3, 0);
    step(6'h00, OP_RD, 3, 0);
    chk("vec_4", last_rd, 32'h80000004);
    step(6'h00, OP_WR, 3, 0);
    step(6'h00, OP_IDLE, 0, 0);
    step(6'h00, OP_RD, 3, 0);
    chk("vec_none", last_rd, 32'h0);
    chk("hw_idle", {26'b0, hw_int}, 32'h0);

    // Nesting: 5 in service, 0 preempts, 5 again blocked
    step(6'h20, OP_IDLE, 0, 0);
    step(6'h00, OP_IDLE, 0, 0);
    step(6'h00, OP_RD, 3, 0);
    chk("vec_5", last_rd, 32'h80000005);
    step(6'h01, OP_IDLE, 0, 0);
    step(6'h00, OP_IDLE, 0, 0);
    chk("hw_nest0", {26'b0, hw_int}, 32'h01);
    step(6'h00, OP_RD, 3, 0);
    chk("vec_0", last_rd, 32'h80000000);
    step(6'h20, OP_IDLE, 0, 0);
    step(6'h00, OP_IDLE, 0, 0);
    step(6'h00, OP_IDLE, 0, 0);
    chk("hw_blocked", {26'b0, hw_int}, 32'h0);
    step(6'h00, OP_WR, 3, 0);
    step(6'h00, OP_WR, 3, 0);
    step(6'h00, OP_RD, 3, 0);
    step(6'h00, OP_RD, 3, 0);
    step(6'h00, OP_WR, 3, 0);

    // Level mode on source 2
    step(6'h00, OP_WR, 2, 32'h00);
    step(6'h04, OP_IDLE, 0, 0);
    step(6'h04, OP_WR, 1, 32'h04);
    step(6'h04, OP_RD, 1, 0);
    chk("lvl_w1c", last_rd, 32'h04);
    step(6'h04, OP_RD, 3, 0);
    chk("lvl_vec", last_rd, 32'h80000002);
    step(6'h04, OP_RD, 1, 0);
    chk("lvl_ack", last_rd, 32'h04);
    step(6'h00, OP_IDLE, 0, 0);
    step(6'h00, OP_RD, 1, 0);
    chk("lvl_drop", last_rd, 32'h0);
    step(6'h00, OP_WR, 3, 0);

    // Masking
    step(6'h00, OP_WR, 2, 32'h3F);
    step(6'h00, OP_WR, 0, 32'h00);
    step(6'h02, OP_IDLE, 0, 0);
    step(6'h00, OP_RD, 1, 0);
    chk("mask_pend", last_rd, 32'h02);
    step(6'h00, OP_RD, 3, 0);
    chk("mask_vec", last_rd, 32'h0);
    chk("mask_hw", {26'b0, hw_int}, 32'h0);
    step(6'h00, OP_WR, 0, 32'h02);
    step(6'h00, OP_IDLE, 0, 0);
    chk("unmask_hw", {26'b0, hw_int}, 32'h02);

    // W1C coinciding with a new edge on source 2
    step(6'h04, OP_WR, 1, 32'h04);
    step(6'h00, OP_RD, 1, 0);
    chk("set_wins", last_rd & 32'h04, 32'h04);

    // Async reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_hw", {26'b0, hw_int}, 32'h0);
    peek_all_zero("async_rd");
    m_reset();
    irq_in = '0;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit [5:0] irq;
      int r;
      irq = 6'($urandom & $urandom);
      r   = $urandom_range(0, 9);
      case (r)
        5: step(irq, OP_RD, $urandom_range(0, 3), 0);
        6: step(irq, OP_WR, 0, $urandom);
        7: step(irq, OP_WR, 2, $urandom);
        8: step(irq, OP_WR, 1, $urandom);
        9: step(irq, OP_WR, 3, $urandom);
        default: step(irq, OP_IDLE, 0, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
